// File: rtl/core_pkg.sv
// Shared core types: pipeline-control FSM states and register-index constants.
// No logic here; imported by the hazard controller and its handshake interface.
package core_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// The master side drives hazard sources; the slave side returns stall/flush controls.
interface hazard_ctrl_if
    import core_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_uses_rt_i;
    logic             idex_memread_i;
    logic [REG_W-1:0] idex_rt_i;
    logic             branch_taken_i;
    logic             mem_req_i;
    logic             mem_ack_i;
    logic             hd_o;
    logic             ifid_hold_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             freeze_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             timeout_o;

    modport master (
        output start_i, id_rs_i, id_rt_i, id_uses_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        input  hd_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, freeze_o,
               stall_cnt_o, timeout_o
    );

    modport slave (
        input  start_i, id_rs_i, id_rt_i, id_uses_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        output hd_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, freeze_o,
               stall_cnt_o, timeout_o
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// One-cycle latency: the count reflects enables sampled at previous edges.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, memory freezes, branch flushes.
// Controls are combinational from state and current inputs; counters update at the edge.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave hif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               timeout_q, timeout_d;
    logic               load_use;
    logic               hd, ifid_hold, ifid_flush, idex_bubble, freeze;
    logic               wait_en, wait_clr;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   stall_cnt;

    // A load writing r0 never creates a real dependency.
    assign load_use = hif.idex_memread_i && (hif.idex_rt_i != ZERO_REG) &&
                      ((hif.idex_rt_i == hif.id_rs_i) ||
                       (hif.id_uses_rt_i && (hif.idex_rt_i == hif.id_rt_i)));

    always_comb begin
        state_d     = state_q;
        hd          = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        freeze      = 1'b0;
        case (state_q)
            ST_INIT: begin
                hd          = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
                if (hif.start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hif.mem_req_i && !hif.mem_ack_i) begin
                    freeze    = 1'b1;
                    hd        = 1'b1;
                    ifid_hold = 1'b1;
                    state_d   = ST_MEM_WAIT;
                end else if (load_use) begin
                    // Branch operands are stale during a load-use stall, so drop the flush.
                    hd          = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end else if (hif.branch_taken_i) begin
                    ifid_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                freeze    = 1'b1;
                hd        = 1'b1;
                ifid_hold = 1'b1;
                if (hif.mem_ack_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign wait_en   = (state_q == ST_MEM_WAIT) && !hif.mem_ack_i;
    assign wait_clr  = (state_q != ST_MEM_WAIT) || hif.mem_ack_i;
    assign timeout_d = timeout_q || (wait_en && (wait_cnt == WAIT_LAST));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_INIT;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (wait_clr),
        .en_i  (wait_en),
        .cnt_o (wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .en_i  (hd && (state_q != ST_INIT)),
        .cnt_o (stall_cnt)
    );

    assign hif.hd_o          = hd;
    assign hif.ifid_hold_o   = ifid_hold;
    assign hif.ifid_flush_o  = ifid_flush;
    assign hif.idex_bubble_o = idex_bubble;
    assign hif.freeze_o      = freeze;
    assign hif.stall_cnt_o   = stall_cnt;
    assign hif.timeout_o     = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    hazard_ctrl_if #(.CNT_W(32)) hif ();

    hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hif   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        hif.start_i        = 1'b0;
        hif.id_rs_i        = '0;
        hif.id_rt_i        = '0;
        hif.id_uses_rt_i   = 1'b0;
        hif.idex_memread_i = 1'b0;
        hif.idex_rt_i      = '0;
        hif.branch_taken_i = 1'b0;
        hif.mem_req_i      = 1'b0;
        hif.mem_ack_i      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_hd", 32'(hif.hd_o), 32'd1);
        chk("rst_hold", 32'(hif.ifid_hold_o), 32'd1);
        chk("rst_bubble", 32'(hif.idex_bubble_o), 32'd1);
        chk("rst_flush", 32'(hif.ifid_flush_o), 32'd0);
        chk("rst_freeze", 32'(hif.freeze_o), 32'd0);
        chk("rst_timeout", 32'(hif.timeout_o), 32'd0);
        chk("rst_stall", hif.stall_cnt_o, 32'd0);

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("init_hd", 32'(hif.hd_o), 32'd1);
            chk("init_stall", hif.stall_cnt_o, 32'd0);
        end

        hif.start_i = 1'b1;
        #1;
        chk("start_cycle_hd", 32'(hif.hd_o), 32'd1);
        tick();
        hif.start_i = 1'b0;
        #1;
        chk("run_hd", 32'(hif.hd_o), 32'd0);
        chk("run_hold", 32'(hif.ifid_hold_o), 32'd0);
        chk("run_bubble", 32'(hif.idex_bubble_o), 32'd0);
        chk("run_flush", 32'(hif.ifid_flush_o), 32'd0);
        chk("run_freeze", 32'(hif.freeze_o), 32'd0);
        chk("run_stall", hif.stall_cnt_o, 32'd0);

        // Load-use on rs
        hif.idex_memread_i = 1'b1;
        hif.idex_rt_i      = 5'd5;
        hif.id_rs_i        = 5'd5;
        #1;
        chk("lu_hd", 32'(hif.hd_o), 32'd1);
        chk("lu_hold", 32'(hif.ifid_hold_o), 32'd1);
        chk("lu_bubble", 32'(hif.idex_bubble_o), 32'd1);
        chk("lu_flush", 32'(hif.ifid_flush_o), 32'd0);
        tick();
        hif.idex_memread_i = 1'b0;
        #1;
        chk("lu_after_hd", 32'(hif.hd_o), 32'd0);
        chk("lu_stall_cnt", hif.stall_cnt_o, 32'd1);

        // Load into r0 never stalls
        hif.idex_memread_i = 1'b1;
        hif.idex_rt_i      = 5'd0;
        hif.id_rs_i        = 5'd0;
        #1;
        chk("lu_r0_hd", 32'(hif.hd_o), 32'd0);
        chk("lu_r0_bubble", 32'(hif.idex_bubble_o), 32'd0);
        tick();
        chk("lu_r0_stall_cnt", hif.stall_cnt_o, 32'd1);

        // rt compare gated by id_uses_rt_i
        hif.idex_rt_i    = 5'd7;
        hif.id_rt_i      = 5'd7;
        hif.id_rs_i      = 5'd3;
        hif.id_uses_rt_i = 1'b0;
        #1;
        chk("rt_unused_hd", 32'(hif.hd_o), 32'd0);
        hif.id_uses_rt_i = 1'b1;
        #1;
        chk("rt_used_hd", 32'(hif.hd_o), 32'd1);
        chk("rt_used_bubble", 32'(hif.idex_bubble_o), 32'd1);
        tick();
        hif.idex_memread_i = 1'b0;
        hif.id_uses_rt_i   = 1'b0;
        #1;
        chk("rt_stall_cnt", hif.stall_cnt_o, 32'd2);

        // Multi-cycle memory: ack on the 4th cycle
        hif.mem_req_i = 1'b1;
        hif.mem_ack_i = 1'b0;
        #1;
        chk("mem_c1_freeze", 32'(hif.freeze_o), 32'd1);
        chk("mem_c1_hd", 32'(hif.hd_o), 32'd1);
        chk("mem_c1_bubble", 32'(hif.idex_bubble_o), 32'd0);
        tick();
        chk("mem_c2_freeze", 32'(hif.freeze_o), 32'd1);
        tick();
        chk("mem_c3_freeze", 32'(hif.freeze_o), 32'd1);
        tick();
        hif.mem_ack_i = 1'b1;
        #1;
        chk("mem_c4_freeze", 32'(hif.freeze_o), 32'd1);
        chk("mem_c4_hold", 32'(hif.ifid_hold_o), 32'd1);
        tick();
        hif.mem_req_i = 1'b0;
        hif.mem_ack_i = 1'b0;
        #1;
        chk("mem_c5_freeze", 32'(hif.freeze_o), 32'd0);
        chk("mem_c5_hd", 32'(hif.hd_o), 32'd0);
        chk("mem_stall_cnt", hif.stall_cnt_o, 32'd6);

        // Single-cycle access
        hif.mem_req_i = 1'b1;
        hif.mem_ack_i = 1'b1;
        #1;
        chk("mem1_freeze", 32'(hif.freeze_o), 32'd0);
        chk("mem1_hd", 32'(hif.hd_o), 32'd0);
        tick();
        hif.mem_req_i = 1'b0;
        hif.mem_ack_i = 1'b0;
        #1;
        chk("mem1_next_freeze", 32'(hif.freeze_o), 32'd0);
        chk("mem1_stall_cnt", hif.stall_cnt_o, 32'd6);

        // Branch alone flushes only
        hif.branch_taken_i = 1'b1;
        #1;
        chk("br_flush", 32'(hif.ifid_flush_o), 32'd1);
        chk("br_hd", 32'(hif.hd_o), 32'd0);
        chk("br_hold", 32'(hif.ifid_hold_o), 32'd0);

        // Load-use beats branch
        hif.idex_memread_i = 1'b1;
        hif.idex_rt_i      = 5'd5;
        hif.id_rs_i        = 5'd5;
        #1;
        chk("lu_br_bubble", 32'(hif.idex_bubble_o), 32'd1);
        chk("lu_br_flush", 32'(hif.ifid_flush_o), 32'd0);

        // Memory freeze beats both
        hif.mem_req_i = 1'b1;
        #1;
        chk("all_freeze", 32'(hif.freeze_o), 32'd1);
        chk("all_bubble", 32'(hif.idex_bubble_o), 32'd0);
        chk("all_flush", 32'(hif.ifid_flush_o), 32'd0);
        chk("all_hd", 32'(hif.hd_o), 32'd1);
        tick();
        hif.idex_memread_i = 1'b0;
        hif.branch_taken_i = 1'b0;
        hif.mem_ack_i      = 1'b1;
        #1;
        chk("all_wait_freeze", 32'(hif.freeze_o), 32'd1);
        tick();
        hif.mem_req_i = 1'b0;
        hif.mem_ack_i = 1'b0;
        #1;
        chk("all_back_freeze", 32'(hif.freeze_o), 32'd0);
        chk("all_stall_cnt", hif.stall_cnt_o, 32'd8);

        // Timeout: enter MEM_WAIT, then 8 wait cycles
        hif.mem_req_i = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("to_before", 32'(hif.timeout_o), 32'd0);
        tick();
        chk("to_set", 32'(hif.timeout_o), 32'd1);
        chk("to_still_frozen", 32'(hif.freeze_o), 32'd1);
        tick();
        tick();
        chk("to_sticky", 32'(hif.timeout_o), 32'd1);
        chk("to_sticky_freeze", 32'(hif.freeze_o), 32'd1);

        // Reset mid-wait
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_timeout", 32'(hif.timeout_o), 32'd0);
        chk("midrst_bubble", 32'(hif.idex_bubble_o), 32'd1);
        chk("midrst_freeze", 32'(hif.freeze_o), 32'd0);
        chk("midrst_stall", hif.stall_cnt_o, 32'd0);
        hif.mem_req_i = 1'b0;

        // Reset wins over start
        rst = 1'b1;
        hif.start_i = 1'b1;
        tick();
        rst = 1'b0;
        hif.start_i = 1'b0;
        #1;
        chk("rst_start_bubble", 32'(hif.idex_bubble_o), 32'd1);
        chk("rst_start_hd", 32'(hif.hd_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. It produces the write-hold `hd_o` consumed by the PC register, plus hold, bubble, flush and freeze controls for the IF/ID and ID/EX pipeline registers. It detects load-use hazards, stalls the whole pipeline across multi-cycle data-memory accesses, and flushes IF/ID on taken branches. It also keeps a saturating stall-cycle counter and a memory-timeout flag for debug.

## Interface
- `REG_W`, 5, register-index width
- `MEM_TIMEOUT`, 64, cycles in MEM_WAIT before `timeout_o` sets
- `CNT_W`, 32, stall-counter width
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `start_i`  in  1  core start pulse, same signal the PC uses
- `id_rs_i`  in  REG_W  rs of the instruction in ID
- `id_rt_i`  in  REG_W  rt of the instruction in ID
- `id_uses_rt_i`  in  1  ID instruction reads rt as a source
- `idex_memread_i`  in  1  instruction in EX is a load
- `idex_rt_i`  in  REG_W  load destination in EX
- `branch_taken_i`  in  1  branch resolved taken in ID this cycle
- `mem_req_i`  in  1  MEM stage issues a data-memory access
- `mem_ack_i`  in  1  data memory completes the access
- `hd_o`  out  1  1 = PC holds its value
- `ifid_hold_o`  out  1  IF/ID keeps its contents
- `ifid_flush_o`  out  1  IF/ID loads a NOP
- `idex_bubble_o`  out  1  ID/EX loads control-zero (bubble)
- `freeze_o`  out  1  EX/MEM and MEM/WB hold
- `stall_cnt_o`  out  CNT_W  cycles with `hd_o`=1 since start
- `timeout_o`  out  1  sticky: a memory access exceeded MEM_TIMEOUT

## Operation
- States: INIT, RUN, MEM_WAIT.
- **INIT** (after reset):
  - `hd_o`=`ifid_hold_o`=`idex_bubble_o`=1; others 0.
  - `start_i`=1 → RUN at the next edge.
  - `start_i` is ignored outside INIT.
- **RUN**:
  - Load-use hazard = `idex_memread_i` && `idex_rt_i`≠0 && (`idex_rt_i`==`id_rs_i` || (`id_uses_rt_i` && `idex_rt_i`==`id_rt_i`)).
  - `mem_req_i` && !`mem_ack_i` → MEM_WAIT at the next edge.
  - Priority in the same cycle:
    1. Memory freeze: `freeze_o`, `hd_o`, `ifid_hold_o`=1; no bubble or flush.
    2. Load-use: `hd_o`, `ifid_hold_o`, `idex_bubble_o`=1. `branch_taken_i` is ignored because its operands are stale.
    3. Branch taken: `ifid_flush_o`=1 only.
  - Otherwise all controls are 0.
  - `mem_req_i` && `mem_ack_i` in the same cycle is a single-cycle access: no freeze, and no MEM_WAIT.
- **MEM_WAIT**:
  - `freeze_o`=`hd_o`=`ifid_hold_o`=1; `idex_bubble_o`=`ifid_flush_o`=0.
  - Wait counter increments each cycle.
  - `mem_ack_i` → RUN at the next edge, and the wait counter clears. The ack cycle itself is still frozen.
  - When the wait counter reaches MEM_TIMEOUT, `timeout_o` sets and stays set until reset. The controller remains in MEM_WAIT.
- `stall_cnt_o` increments on every edge where `hd_o`=1 and state≠INIT. It saturates at all-ones.
- Load-use and branch controls are combinational in RUN. Freeze outputs are derived from state plus the current `mem_req_i`/`mem_ack_i`.

## Timing
- Reset values: state=INIT, `hd_o`=1, `ifid_hold_o`=1, `idex_bubble_o`=1, `ifid_flush_o`=0, `freeze_o`=0, `stall_cnt_o`=0, `timeout_o`=0, wait counter=0.
- A load-use stall lasts exactly 1 cycle. The bubble clears `idex_memread_i` on the next cycle, so the stall cannot repeat.
- Freeze length = cycles from `mem_req_i` to `mem_ack_i`, inclusive.
- `rst_i` in any state, including mid-MEM_WAIT, returns to INIT at that edge. `rst_i` wins over `start_i`.
- `start_i` and `rst_i` asserted together → INIT.

## Structure
- Shared package `core_pkg` holds:
  - state enum (INIT, RUN, MEM_WAIT)
  - `REG_W`
  - zero-register constant
- Optional sub-module `sat_counter` (width param, enable, sync clear), used for both `stall_cnt_o` and the wait counter.

## Test plan
- **Reset/start:** reset, idle 3 cycles, then pulse `start_i`.
  - INIT cycles: `hd_o`=1, `stall_cnt_o`=0.
  - Next cycle: RUN with all controls 0.
- **Load-use:** `idex_memread_i`=1, `idex_rt_i`=5, `id_rs_i`=5.
  - `hd_o`, `ifid_hold_o`, `idex_bubble_o`=1 for 1 cycle.
  - `stall_cnt_o`=1.
  - Repeat with `idex_rt_i`=0: no stall.
- **rt compare:** `idex_rt_i`=7, `id_rt_i`=7.
  - With `id_uses_rt_i`=0: no stall.
  - With `id_uses_rt_i`=1: stall.
- **Multi-cycle memory:** `mem_req_i`=1, `mem_ack_i` on the 4th cycle.
  - `freeze_o`=1 for 4 cycles.
  - RUN on the 5th cycle.
  - Repeat with req and ack in the same cycle: no freeze.
- **Simultaneous events:** load-use and `branch_taken_i` together.
  - Bubble asserted, no flush.
  - With `mem_req_i` also pending: freeze only.
- **Timeout/reset mid-wait:** `mem_req_i` held with no ack, MEM_TIMEOUT=8.
  - `timeout_o`=1 after 8 wait cycles.
  - Assert `rst_i`: INIT next cycle, `timeout_o`=0.
